// File: rtl/fft_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_serializer
//  Purpose  : Captures 16-point FFT frames (16 x 32-bit, {re,im}) into a
//             two-frame ping-pong store. Streams them out one point per
//             cycle over valid/ready. Reports the peak-magnitude bin of
//             each streamed frame.
//  Ports    : clk, rst (async, active-low)
//             fft_valid, fft_d0..fft_d15   - frame input strobe + points
//             out_ready/out_valid/out_data/out_idx/out_last - point stream
//             peak_valid/peak_idx          - per-frame peak result
//             drop/drop_cnt                - discarded-frame pulse/counter
//  Revision : 1.0 - initial release
// ============================================================================
module fft_frame_serializer #(
    parameter int SKIP_DC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        peak_valid,
    output logic [3:0]  peak_idx,
    output logic        drop,
    output logic [7:0]  drop_cnt
);

    // First bin that takes part in the peak search.
    localparam logic [3:0] c_START = (SKIP_DC != 0) ? 4'd1 : 4'd0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] buf_q [2][16];
    logic [1:0]  full_q,      full_d;
    logic        wsel_q,      wsel_d;
    logic        rsel_q,      rsel_d;
    logic [3:0]  rp_q,        rp_d;
    state_t      state_q,     state_d;
    logic [17:0] max_mag_q,   max_mag_d;
    logic [3:0]  max_idx_q,   max_idx_d;
    logic        peak_valid_q, peak_valid_d;
    logic [3:0]  peak_idx_q,  peak_idx_d;
    logic        drop_q,      drop_d;
    logic [7:0]  drop_cnt_q,  drop_cnt_d;

    // ------------------------------------------------------------------
    // Input frame gathered into an array
    // ------------------------------------------------------------------
    logic [31:0] w_frame [16];

    assign w_frame[0]  = fft_d0;
    assign w_frame[1]  = fft_d1;
    assign w_frame[2]  = fft_d2;
    assign w_frame[3]  = fft_d3;
    assign w_frame[4]  = fft_d4;
    assign w_frame[5]  = fft_d5;
    assign w_frame[6]  = fft_d6;
    assign w_frame[7]  = fft_d7;
    assign w_frame[8]  = fft_d8;
    assign w_frame[9]  = fft_d9;
    assign w_frame[10] = fft_d10;
    assign w_frame[11] = fft_d11;
    assign w_frame[12] = fft_d12;
    assign w_frame[13] = fft_d13;
    assign w_frame[14] = fft_d14;
    assign w_frame[15] = fft_d15;

    // ------------------------------------------------------------------
    // Handshake / capture qualifiers
    // ------------------------------------------------------------------
    logic        w_capture;
    logic        w_drop_now;
    logic        w_hs;
    logic        w_release;
    logic [31:0] w_rd_word;

    // FULL flags are sampled before the edge, so a buffer released by the
    // idx-15 handshake on this same edge still counts as occupied here.
    assign w_capture  = fft_valid &  ~full_q[wsel_q];
    assign w_drop_now = fft_valid &   full_q[wsel_q];
    assign w_hs       = (state_q == S_DRAIN) & out_ready;
    assign w_release  = w_hs & (rp_q == 4'd15);
    assign w_rd_word  = buf_q[rsel_q][rp_q];

    // ------------------------------------------------------------------
    // Magnitude |re| + |im|; 17-bit absolute values so -32768 maps to
    // +32768 without wrapping, 18-bit sum.
    // ------------------------------------------------------------------
    logic [15:0] w_re;
    logic [15:0] w_im;
    logic [16:0] w_abs_re;
    logic [16:0] w_abs_im;
    logic [17:0] w_mag;

    assign w_re     = w_rd_word[31:16];
    assign w_im     = w_rd_word[15:0];
    assign w_abs_re = w_re[15] ? (17'd0 - {1'b1, w_re}) : {1'b0, w_re};
    assign w_abs_im = w_im[15] ? (17'd0 - {1'b1, w_im}) : {1'b0, w_im};
    assign w_mag    = {1'b0, w_abs_re} + {1'b0, w_abs_im};

    // Restart at the first searched bin; afterwards only a strictly larger
    // magnitude wins, so ties keep the lower bin.
    logic       w_take;
    logic [3:0] w_cand_idx;

    assign w_take     = (rp_q == c_START) |
                        ((rp_q > c_START) & (w_mag > max_mag_q));
    assign w_cand_idx = w_take ? rp_q : max_idx_q;

    // ------------------------------------------------------------------
    // Buffer flags, select pointers, peak and drop bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        full_d       = full_q;
        wsel_d       = wsel_q;
        rsel_d       = rsel_q;
        rp_d         = rp_q;
        max_mag_d    = max_mag_q;
        max_idx_d    = max_idx_q;
        peak_valid_d = 1'b0;
        peak_idx_d   = peak_idx_q;
        drop_d       = w_drop_now;
        drop_cnt_d   = drop_cnt_q;

        if (w_release) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
        end
        // No conflict with the release above: a capture needs the target
        // buffer empty, and the buffer being drained is always FULL.
        if (w_capture) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = ~wsel_q;
        end

        if (w_hs) begin
            rp_d = rp_q + 4'd1;
            if (w_take) begin
                max_mag_d = w_mag;
                max_idx_d = rp_q;
            end
        end
        if (w_release) begin
            peak_valid_d = 1'b1;
            peak_idx_d   = w_cand_idx;
        end

        if (w_drop_now && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Reader FSM next state. Looking at full_d (not full_q) lets a frame
    // captured on this edge start draining in the very next cycle, and lets
    // a back-to-back frame follow the idx-15 point without a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (full_d[rsel_q]) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_release && !full_d[~rsel_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            full_q       <= 2'b00;
            wsel_q       <= 1'b0;
            rsel_q       <= 1'b0;
            rp_q         <= 4'd0;
            max_mag_q    <= 18'd0;
            max_idx_q    <= 4'd0;
            peak_valid_q <= 1'b0;
            peak_idx_q   <= 4'd0;
            drop_q       <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            wsel_q       <= wsel_d;
            rsel_q       <= rsel_d;
            rp_q         <= rp_d;
            max_mag_q    <= max_mag_d;
            max_idx_q    <= max_idx_d;
            peak_valid_q <= peak_valid_d;
            peak_idx_q   <= peak_idx_d;
            drop_q       <= drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Frame storage carries no reset; its contents are only observed while
    // the matching FULL flag is set.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < 16; k++) begin
                buf_q[wsel_q][k] <= w_frame[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all derived from registered state. Data is gated to zero
    // outside DRAIN so reset (which forces IDLE) zeroes it at once.
    // ------------------------------------------------------------------
    assign out_valid  = (state_q == S_DRAIN);
    assign out_data   = out_valid ? w_rd_word : 32'd0;
    assign out_idx    = rp_q;
    assign out_last   = out_valid & (rp_q == 4'd15);
    assign peak_valid = peak_valid_q;
    assign peak_idx   = peak_idx_q;
    assign drop       = drop_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_frame_serializer
//  Purpose  : Self-checking bench for fft_frame_serializer. A frame-level
//             reference model (queue of stored frames, read position,
//             arithmetic peak search) predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_serializer;

    localparam int SKIP_DC = 1;

    typedef logic [31:0] frame_t [16];

    logic        clk = 1'b0;
    logic        rst;
    logic        fft_valid;
    logic        out_ready;
    logic [31:0] d [16];
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        peak_valid;
    logic [3:0]  peak_idx;
    logic        drop;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    fft_frame_serializer #(.SKIP_DC(SKIP_DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .fft_valid  (fft_valid),
        .fft_d0     (d[0]),
        .fft_d1     (d[1]),
        .fft_d2     (d[2]),
        .fft_d3     (d[3]),
        .fft_d4     (d[4]),
        .fft_d5     (d[5]),
        .fft_d6     (d[6]),
        .fft_d7     (d[7]),
        .fft_d8     (d[8]),
        .fft_d9     (d[9]),
        .fft_d10    (d[10]),
        .fft_d11    (d[11]),
        .fft_d12    (d[12]),
        .fft_d13    (d[13]),
        .fft_d14    (d[14]),
        .fft_d15    (d[15]),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx),
        .drop       (drop),
        .drop_cnt   (drop_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model state (describes the DUT after the latest edge)
    // ------------------------------------------------------------------
    frame_t     mq [$];     // frames held in the store, oldest first
    int         ptr;        // next point of mq[0] to be handed out
    logic       e_drop;
    logic       e_pv;
    logic [3:0] e_pidx;
    int         e_dcnt;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mag_of(input logic [31:0] w);
        int re;
        int im;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        return ((re < 0) ? -re : re) + ((im < 0) ? -im : im);
    endfunction

    // Lowest bin holding the largest magnitude, bin 0 optionally excluded.
    function automatic logic [3:0] ref_peak(input frame_t f);
        int best;
        int bi;
        best = -1;
        bi   = 0;
        for (int k = SKIP_DC; k < 16; k++) begin
            if (mag_of(f[k]) > best) begin
                best = mag_of(f[k]);
                bi   = k;
            end
        end
        return 4'(bi);
    endfunction

    task automatic model_reset();
        mq.delete();
        ptr    = 0;
        e_drop = 1'b0;
        e_pv   = 1'b0;
        e_pidx = 4'd0;
        e_dcnt = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, (mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", out_data, mq[0][ptr]);
            chk("out_idx",  out_idx,  ptr);
            chk("out_last", out_last, (ptr == 15));
        end
        chk("peak_valid", peak_valid, e_pv);
        chk("peak_idx",   peak_idx,   e_pidx);
        chk("drop",       drop,       e_drop);
        chk("drop_cnt",   drop_cnt,   e_dcnt);
    endtask

    // One clock: check the state left by the previous edge, drive the next
    // edge's inputs, and advance the model across that edge.
    task automatic cyc(input logic fv, input frame_t f, input logic rdy);
        logic hs;
        logic cap;
        @(negedge clk);
        check_outputs();
        fft_valid = fv;
        d         = f;
        out_ready = rdy;

        hs     = (mq.size() > 0) && rdy;
        cap    = fv && (mq.size() < 2);
        e_pv   = 1'b0;
        e_drop = fv && !cap;
        if (e_drop && e_dcnt < 255) e_dcnt++;
        if (hs) begin
            if (ptr == 15) begin
                e_pidx = ref_peak(mq[0]);
                e_pv   = 1'b1;
                void'(mq.pop_front());
                ptr = 0;
            end else begin
                ptr++;
            end
        end
        if (cap) mq.push_back(f);
    endtask

    task automatic idle(input int n, input logic rdy);
        frame_t z;
        foreach (z[k]) z[k] = 32'd0;
        for (int i = 0; i < n; i++) cyc(1'b0, z, rdy);
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        logic [15:0] sp [4];
        sp[0] = 16'h8000; sp[1] = 16'h7FFF; sp[2] = 16'h0000; sp[3] = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0:       f[k] = $urandom;
                1:       f[k] = {sp[$urandom_range(0, 3)], sp[$urandom_range(0, 3)]};
                default: f[k] = {16'($urandom_range(0, 7)) - 16'd3, 16'($urandom_range(0, 7)) - 16'd3};
            endcase
        end
        return f;
    endfunction

    frame_t fa, fb, fc;

    initial begin
        rst       = 1'b0;
        fft_valid = 1'b0;
        out_ready = 1'b0;
        foreach (d[k]) d[k] = 32'd0;
        model_reset();

        // Reset state
        #12;
        check_outputs();
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_idx",  out_idx,  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single frame, ramp on the real part
        foreach (fa[k]) fa[k] = {16'(k * 4), 16'h0000};
        cyc(1'b1, fa, 1'b1);
        idle(20, 1'b1);
        chk("single_peak_idx", peak_idx, 32'd15);

        // Backpressure 1,0,0 repeating
        cyc(1'b1, fa, 1'b1);
        for (int i = 0; i < 60; i++) begin
            frame_t z;
            foreach (z[k]) z[k] = 32'd0;
            cyc(1'b0, z, ((i % 3) == 2));
        end

        // Ping-pong: two frames three cycles apart
        fb = rand_frame();
        cyc(1'b1, fa, 1'b1);
        idle(2, 1'b1);
        cyc(1'b1, fb, 1'b1);
        idle(35, 1'b1);
        chk("pingpong_drop_cnt", drop_cnt, 32'd0);

        // Overflow: three frames while stalled, the third is discarded
        fc = rand_frame();
        cyc(1'b1, fa, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, fb, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, fc, 1'b0);
        idle(3, 1'b0);
        chk("overflow_drop_cnt", drop_cnt, 32'd1);
        idle(40, 1'b1);

        // Equal magnitudes at bins 3 and 9, both the -32768 extreme
        foreach (fa[k]) fa[k] = 32'd0;
        fa[3] = {16'h8000, 16'h0000};
        fa[9] = {16'h0000, 16'h8000};
        cyc(1'b1, fa, 1'b1);
        idle(20, 1'b1);
        chk("tie_peak_idx", peak_idx, 32'd3);

        // Largest point sits in bin 0, which the search skips
        foreach (fa[k]) fa[k] = 32'd0;
        fa[0] = {16'h7FFF, 16'h7FFF};
        fa[5] = {16'h0001, 16'h0000};
        cyc(1'b1, fa, 1'b1);
        idle(20, 1'b1);
        chk("skipdc_peak_idx", peak_idx, 32'd5);

        // Reset in the middle of a drain
        fb = rand_frame();
        cyc(1'b1, fb, 1'b1);
        idle(7, 1'b1);
        @(negedge clk);
        check_outputs();
        chk("pre_reset_idx", out_idx, 32'd7);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("mid_reset_out_valid", out_valid, 32'd0);
        chk("mid_reset_out_data",  out_data,  32'd0);
        chk("mid_reset_out_idx",   out_idx,   32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle(3, 1'b1);
        foreach (fa[k]) fa[k] = {16'h0000, 16'(k * 4)};
        fa[11] = {16'hF000, 16'h0000};
        cyc(1'b1, fa, 1'b1);
        idle(20, 1'b1);
        chk("post_reset_peak_idx", peak_idx, 32'd11);

        // Randomised traffic and backpressure
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) == 0), rand_frame(), ($urandom_range(0, 3) != 0));
        end
        idle(60, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Sink for the FAS FFT result port. Captures each 16-point frame presented on `fft_d0`..`fft_d15` under `fft_valid`, buffers it in a two-frame ping-pong store, and streams it out one point per cycle over a valid/ready handshake. While streaming, it computes the peak-magnitude bin of each frame. It sits between FAS and any downstream consumer that cannot take 512 bits in a single cycle.

## Interface
Parameters
- `SKIP_DC`, default 1: when 1, bin 0 is excluded from the peak search. It is still streamed.

Ports
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `fft_valid` input 1: one-cycle frame strobe from FAS.
- `fft_d0`..`fft_d15` input 32 each: point k. Bits [31:16] are real, [15:0] are imaginary. Both are signed two's complement.
- `out_ready` input 1: downstream accepts the current point.
- `out_valid` output 1: `out_data` holds a valid point.
- `out_data` output 32: current point, same packing as the input.
- `out_idx` output 4: bin index of the current point, 0..15.
- `out_last` output 1: high with the valid point whose `out_idx` is 15.
- `peak_valid` output 1: one-cycle pulse when a frame's peak is final.
- `peak_idx` output 4: peak bin of the most recently completed frame. Held between pulses.
- `drop` output 1: one-cycle pulse when an incoming frame is discarded.
- `drop_cnt` output 8: count of discarded frames. Saturates at 255.

## Operation
- Storage: two 16x32 frame buffers, B0 and B1. Each has a FULL flag.
  - `wsel` selects the next buffer to write.
  - `rsel` selects the buffer being read.
  - Both reset to B0.
- Capture:
  - At a rising edge with `fft_valid`=1 and buffer[`wsel`] not FULL (as sampled before the edge), all 16 words are written, buffer[`wsel`] is set FULL, and `wsel` toggles.
  - If buffer[`wsel`] is FULL, the frame is dropped: `drop` pulses and `drop_cnt` increments.
- Reader FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN when buffer[`rsel`] is FULL. The read pointer `rp` is 0.
  - In DRAIN, `out_valid`=1, `out_data`=buffer[`rsel`][`rp`], `out_idx`=`rp`, `out_last`=(`rp`==15).
  - A handshake is `out_valid`&`out_ready` at a rising edge. On each handshake, `rp` increments.
  - On a handshake with `rp`==15: buffer[`rsel`] is cleared to not-FULL, `rsel` toggles, and `rp` returns to 0.
    - If the other buffer is FULL, the FSM stays in DRAIN with no bubble.
    - Otherwise it goes to IDLE.
- `out_data`/`out_idx` must hold stable while `out_valid`=1 and `out_ready`=0.
- Peak search, over handshaken points only:
  - mag = |re| + |im|, computed unsigned at 18 bits. |−32768| = 32768 must not wrap.
  - At `rp`==0, the running maximum restarts, unless `SKIP_DC`=1, in which case bin 0 is skipped and the search restarts at bin 1.
  - A candidate replaces the current maximum only if strictly greater, so ties go to the lowest index.
  - On the handshake of point 15, `peak_idx` is loaded and `peak_valid` pulses.
- Simultaneous events:
  - A buffer released by the `rp`==15 handshake at edge T is not writable by an `fft_valid` at the same edge T. Such a frame is dropped if `wsel` points to that buffer.
  - Capture into the other buffer while draining is always allowed.
- Reset asserted mid-operation:
  - Both FULL flags clear, the FSM goes to IDLE, and `rp`, `wsel`, and `rsel` return to 0/B0.
  - Any partially streamed frame is abandoned, with no `peak_valid` for it.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `peak_valid`=0, `peak_idx`=0, `drop`=0, `drop_cnt`=0.
- Latency: with `fft_valid` at edge T into an empty block, `out_valid`=1 and idx 0 appear in the cycle after T, driven from registered state.
- Full frame with `out_ready` held high: 16 consecutive cycles, idx 0..15.
- `peak_valid` and its `peak_idx` are registered and appear in the cycle after the idx-15 handshake.
- `drop` is registered and appears in the cycle after the dropping edge.
- Sustained throughput is one frame per 16 cycles. FAS frame spacing in normal operation is at least 16 cycles, so no drops are expected with `out_ready`=1.

## Test plan
- Single frame: point k = {16'(k*4), 16'h0000}, `out_ready`=1 -> `out_valid` one cycle after `fft_valid`. Idx 0..15 in order with data matching. `out_last` only at idx 15. `peak_idx`=15 and `peak_valid` one cycle after the last handshake.
- Backpressure: the same frame with `out_ready` toggling 1,0,0,1,… -> no point skipped or duplicated, and data/idx stable during stall cycles.
- Ping-pong: two frames 3 cycles apart with `out_ready`=1 -> 32 contiguous valid cycles with no bubble at the frame boundary. `drop_cnt`=0.
- Overflow: `out_ready`=0, then three frames -> the third pulses `drop` and `drop_cnt`=1. After releasing `out_ready`, exactly frames 1 and 2 emerge.
- Peak corner cases:
  - Bin 3 = {16'h8000, 0} and bin 9 = {0, 16'h8000}, all others 0 -> `peak_idx`=3 (tie goes to the lowest index, no wrap).
  - Bin 0 = {16'h7FFF, 16'h7FFF} with `SKIP_DC`=1 -> bin 0 is ignored.
- Reset mid-drain: assert `rst`=0 at idx 7 -> all outputs 0 immediately. After release, a new frame streams from idx 0 and gives the correct `peak_idx`.
